wide_logic_unit: RTL and testbench
==================================

# wide_logic_unit

Parametrised, multi-cycle bitwise logic unit for wide operands. Accepts two WIDTH-bit operands and an op code over a valid/ready handshake, then processes them one CHUNK-bit slice per cycle through a single shared slice datapath. After the last slice it presents the WIDTH-bit result and an all-zero flag. It generalises the fixed-width, AND-only, fully parallel wide gate into a selectable-op, area-reduced, handshaked block for the wide-vector datapath.

## Interface
- WIDTH, 1024, operand and result width in bits; must be a positive multiple of CHUNK.
- CHUNK, 32, bits processed per cycle.
- NCHUNK (derived, not overridable), WIDTH/CHUNK, number of slices.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream operands valid.
- in_ready  out  1  block can accept operands.
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- c  out  WIDTH  result, registered.
- zero  out  1  result is all zeros, registered.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept occurs when in_valid && in_ready.
- On accept: register a, b, op; clear slice index idx to 0; clear the zero accumulator to 1; go to RUN.
- RUN: each cycle, compute slice idx, c[idx*CHUNK +: CHUNK] = op(a_q, b_q) on that slice. AND accumulator with (slice==0). Increment idx. When idx==NCHUNK-1, go to DONE and set zero from the final accumulated value.
- DONE: out_valid=1; c and zero held stable. On out_ready, go to IDLE. If a new accept occurs in the same cycle, go directly to RUN instead.
- Inputs a, b, op are sampled only on accept; changes at any other time have no effect.
- op is not re-sampled during RUN. All four ops are supported on every slice; NOR is the bitwise inverse of OR.
- The index counter is max(1, clog2(NCHUNK)) bits wide. For NCHUNK=1, RUN lasts exactly one cycle.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=1, out_valid=0, c=0, zero=0, idx=0, and all operand registers 0. Reset mid-RUN or mid-DONE abandons the transaction with no output.
- Latency: with accept at edge N, out_valid rises after edge N+NCHUNK.
- Throughput: with out_ready held at 1, one result every NCHUNK+1 cycles.
- During RUN, c holds a mix of new slices and the previous result. c is only meaningful while out_valid=1.
- out_valid, once high, stays high with c and zero unchanged until out_ready is sampled high.
- out_valid is never asserted in the same cycle as state==RUN.

## Structure
- A shared package holds the op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the FSM state typedef.
- One sub-module, bitwise_op_chunk: purely combinational, parameter CHUNK, ports op, a, b, y. It is instantiated once and muxed by idx.
- The top level contains the FSM, idx counter, operand registers, result register, and zero accumulator.

## Test plan
- Use WIDTH=1024, CHUNK=32. Reset, then drive a=all ones, b=0xA5 repeated, op=AND, out_ready=1. Expect c=0xA5 repeated, zero=0, out_valid exactly 32 cycles after accept, and out_valid high for 1 cycle.
- Drive a=b=random, op=XOR. Expect c=0 and zero=1. Then drive the same a and b with op=NOR and check c against ~(a|b).
- Hold out_ready=0 for 10 cycles after out_valid. Expect c, zero, and out_valid stable, and in_ready=0. Then raise out_ready together with in_valid carrying new operands. Expect a same-cycle accept and the next out_valid 32 cycles later.
- Change a, b, and op every cycle during RUN. Expect the result to match only the values sampled at accept.
- Assert rst_n low at slice 15 of a RUN. Expect outputs immediately at reset values and no out_valid. After release, a fresh transaction completes correctly.
- Use WIDTH=CHUNK=32 with op=OR, a=0x0000FFFF, b=0xFFFF0000. Expect c=0xFFFFFFFF, zero=0, and out_valid 1 cycle after accept.

Source files
------------

// File: rtl/wide_logic_unit_pkg.sv
// Shared encodings for the wide bitwise logic unit: op codes and FSM states.
package wide_logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Plain vector states keep the encoding visible to legacy tooling.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/wide_logic_unit_bitwise_op_chunk.sv
// One CHUNK-bit slice of the selectable bitwise operation (pure combinational).
module bitwise_op_chunk
  import wide_logic_unit_pkg::*;
#(
  parameter int CHUNK = 32
) (
  input  logic [1:0]       op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  // Select the slice result; NOR is the inverse of OR.
  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/wide_logic_unit.sv
// Multi-cycle wide bitwise unit: one shared CHUNK-bit slice per cycle,
// WIDTH-bit result and all-zero flag presented over valid/ready.
module wide_logic_unit
  import wide_logic_unit_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, b_q, c_q;
  logic [1:0]        op_q;
  logic              acc_q, acc_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic              last;
  logic [CHUNK-1:0]  a_sl, b_sl, y_sl;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == IDXW'(NCHUNK - 1));
  assign out_valid = (state_q == ST_DONE);
  assign c         = c_q;
  assign zero      = zero_q;

  // Slice selection; a single-slice configuration needs no mux.
  if (NCHUNK == 1) begin : g_one
    assign a_sl = a_q;
    assign b_sl = b_q;
  end else begin : g_mux
    logic [NCHUNK-1:0][CHUNK-1:0] a_v, b_v;
    assign a_v  = a_q;
    assign b_v  = b_q;
    assign a_sl = a_v[idx_q];
    assign b_sl = b_v[idx_q];
  end

  bitwise_op_chunk #(.CHUNK(CHUNK)) u_chunk (
    .op (op_q),
    .a  (a_sl),
    .b  (b_sl),
    .y  (y_sl)
  );

  // Next-state: FSM, slice index, zero accumulator and final zero flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          idx_d   = '0;
          acc_d   = 1'b1;
        end
      end
      ST_RUN: begin
        acc_d = acc_q & ~(|y_sl);
        if (last) begin
          state_d = ST_DONE;
          idx_d   = '0;
          zero_d  = acc_d;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = ST_RUN;
            idx_d   = '0;
            acc_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
    end
  end

  // Operands are captured only on accept so upstream may change them freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  // Write the current slice of the result; other slices hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
    end else if (state_q == ST_RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (idx_q == IDXW'(i)) c_q[i*CHUNK +: CHUNK] <= y_sl;
      end
    end
  end

endmodule

// File: tb/tb_wide_logic_unit.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on handshake.
module tb_wide_logic_unit;
  import wide_logic_unit_pkg::*;

  localparam int W  = 1024;
  localparam int C  = 32;
  localparam int N  = W / C;
  localparam int W2 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 1: 1024/32
  logic          in_valid, in_ready, out_valid, out_ready, zero;
  logic [1:0]    op;
  logic [W-1:0]  a, b, c;
  // DUT 2: 32/32
  logic          in_valid2, in_ready2, out_valid2, out_ready2, zero2;
  logic [1:0]    op2;
  logic [W2-1:0] a2, b2, c2;

  wide_logic_unit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .zero(zero)
  );

  wide_logic_unit #(.WIDTH(W2), .CHUNK(C)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .c(c2), .zero(zero2)
  );

  typedef struct {
    logic [W-1:0] c;
    logic         z;
    int           acc;
  } sb_t;

  sb_t sb[$];
  sb_t sb2[$];

  int checks = 0;
  int passes = 0;

  task automatic check_vec(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    int s;
    s = 0;
    checks++;
    if (got === exp) passes++;
    else begin
      for (int i = N - 1; i >= 0; i--)
        if (got[i*C +: C] !== exp[i*C +: C]) s = i;
      $display("FAIL %s: slice %0d got %h expected %h", nm, s, got[s*C +: C], exp[s*C +: C]);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Monitor for DUT 1: latency on rising out_valid, data on handshake.
  initial begin
    logic prev;
    logic hs_prev;
    prev = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        hs_prev = 1'b0;
        continue;
      end
      if (hs_prev) check_val("valid_drops_after_handshake", 32'(out_valid), 32'd0);
      hs_prev = 1'b0;
      if (out_valid && !prev) begin
        if (sb.size() == 0) fail_now("spurious_out_valid");
        else check_val("latency", 32'(cyc - sb[0].acc), 32'(N));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail_now("handshake_without_expect");
        else begin
          sb_t e;
          e = sb.pop_front();
          check_vec("result_c", c, e.c);
          check_val("result_zero", 32'(zero), 32'(e.z));
          hs_prev = 1'b1;
        end
      end
      prev = out_valid;
    end
  end

  // Monitor for DUT 2.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        continue;
      end
      if (out_valid2 && !prev) begin
        if (sb2.size() == 0) fail_now("spurious_out_valid2");
        else check_val("latency2", 32'(cyc - sb2[0].acc), 32'd1);
      end
      if (out_valid2 && out_ready2) begin
        if (sb2.size() == 0) fail_now("handshake_without_expect2");
        else begin
          sb_t e;
          e = sb2.pop_front();
          check_val("result_c2", c2, e.c[W2-1:0]);
          check_val("result_zero2", 32'(zero2), 32'(e.z));
        end
      end
      prev = out_valid2;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ec, input logic ez, output int waited);
    bit ok;
    sb_t e;
    ok = 0;
    waited = 0;
    a = av; b = bv; op = o; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) fail_now("accept_timeout");
    else begin
      e.c = ec; e.z = ez; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send2(input logic [1:0] o, input logic [W2-1:0] av, input logic [W2-1:0] bv,
                       input logic [W2-1:0] ec, input logic ez);
    bit ok;
    sb_t e;
    ok = 0;
    a2 = av; b2 = bv; op2 = o; in_valid2 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready2) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    if (!ok) fail_now("accept_timeout2");
    else begin
      e.c = W'(ec); e.z = ez; e.acc = cyc;
      sb2.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && sb2.size() == 0) begin ok = 1; break; end
    end
    if (!ok) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones, a5, r, x, y, hi, cap_c;
    logic         cap_z;
    int           w;
    bit           ok;
    ones = '1;
    a5   = {128{8'hA5}};
    x    = {32{32'h12345678}};
    y    = {32{32'h0F0F0F0F}};
    hi   = '0;
    hi[W-1] = 1'b1;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();

    in_valid = 0; out_ready = 1; op = 0; a = '0; b = '0;
    in_valid2 = 0; out_ready2 = 1; op2 = 0; a2 = '0; b2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_in_ready", 32'(in_ready), 32'd1);
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_vec("reset_c", c, '0);
    check_val("reset_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AND with all-ones passes b through
    send(OP_AND, ones, a5, a5, 1'b0, w);
    drain();

    // XOR of equal operands, then NOR of the same pair
    send(OP_XOR, r, r, '0, 1'b1, w);
    drain();
    send(OP_NOR, r, r, ~r, (~r) == '0, w);
    drain();

    // Only the final slice nonzero; all-zero OR
    send(OP_AND, hi, hi, hi, 1'b0, w);
    send(OP_OR, '0, '0, '0, 1'b1, w);
    drain();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(OP_XOR, x, y, {32{32'h1D3B5977}}, 1'b0, w);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) fail_now("backpressure_valid_timeout");
    cap_c = c; cap_z = zero;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_vec("hold_c", c, {32{32'h1D3B5977}});
      check_val("hold_zero", 32'(zero), 32'(cap_z));
      check_val("hold_out_valid", 32'(out_valid), 32'd1);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_AND, x, y, {32{32'h02040608}}, 1'b0, w);
    check_val("same_cycle_accept", 32'(w), 32'd0);
    drain();

    // Operand changes during RUN must be ignored
    send(OP_OR, x, y, {32{32'h1F3F5F7F}}, 1'b0, w);
    for (int i = 0; i < 40; i++) begin
      a = {32{$urandom()}}; b = {32{$urandom()}}; op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    drain();

    // Reset mid-RUN abandons the transaction
    send(OP_XOR, x, y, {32{32'h1D3B5977}}, 1'b0, w);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_val("midreset_out_valid", 32'(out_valid), 32'd0);
    check_val("midreset_in_ready", 32'(in_ready), 32'd1);
    check_vec("midreset_c", c, '0);
    check_val("midreset_zero", 32'(zero), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("inreset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_val("post_reset_no_valid", 32'(out_valid), 32'd0);
      if (i == 3) break;
    end
    @(posedge clk); #1;
    send(OP_NOR, x, y, {32{32'hE0C0A080}}, 1'b0, w);
    drain();

    // Single-slice instance
    send2(OP_OR, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0);
    drain();
    send2(OP_XOR, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b1);
    send2(OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
